// File: rtl/multi_queue_fifo.sv
// multi_queue_fifo
//   NUM_QUEUES independent FIFOs sharing one storage array addressed as
//   {qid, ptr}. One enqueue and one dequeue per cycle, each to any queue.
//   Illegal operations are dropped and recorded in sticky per-queue bits.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset (pointers, counts, errors)
//   flush_en      per-queue synchronous flush, overrides enq/deq to that queue
//   enqueue_en    write value_i to queue enqueue_qid
//   enqueue_qid   enqueue target queue
//   value_i       enqueue data
//   dequeue_en    pop the head of queue dequeue_qid
//   dequeue_qid   dequeue / read target queue
//   value_o       head entry of queue dequeue_qid (combinational)
//   full, almost_full, empty, almost_empty   per-queue flags from count
//   overflow, underflow                      sticky per-queue error bits
//
// Handshake: there is no ready signal. enqueue_en/dequeue_en act as valid
// strobes sampled at the rising edge; the caller consults full/empty to
// avoid drops. A strobe that cannot be honoured is discarded and sets the
// matching sticky error bit of the targeted queue (unless that queue is
// being flushed in the same cycle).
module multi_queue_fifo #(
    parameter int DATA_WIDTH             = 64,
    parameter int NUM_QUEUES             = 4,
    parameter int ENTRIES_PER_QUEUE      = 4,
    parameter int ALMOST_FULL_THRESHOLD  = ENTRIES_PER_QUEUE,
    parameter int ALMOST_EMPTY_THRESHOLD = 1,
    localparam int QID_WIDTH = $clog2(NUM_QUEUES),
    localparam int PTR_WIDTH = $clog2(ENTRIES_PER_QUEUE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_QUEUES-1:0] flush_en,
    input  logic                  enqueue_en,
    input  logic [QID_WIDTH-1:0]  enqueue_qid,
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic                  dequeue_en,
    input  logic [QID_WIDTH-1:0]  dequeue_qid,
    output logic [DATA_WIDTH-1:0] value_o,
    output logic [NUM_QUEUES-1:0] full,
    output logic [NUM_QUEUES-1:0] almost_full,
    output logic [NUM_QUEUES-1:0] empty,
    output logic [NUM_QUEUES-1:0] almost_empty,
    output logic [NUM_QUEUES-1:0] overflow,
    output logic [NUM_QUEUES-1:0] underflow
);

    localparam int CNT_WIDTH  = PTR_WIDTH + 1;
    localparam int ADDR_WIDTH = QID_WIDTH + PTR_WIDTH;
    localparam int TOTAL      = NUM_QUEUES * ENTRIES_PER_QUEUE;

    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(ENTRIES_PER_QUEUE);
    localparam logic [CNT_WIDTH-1:0] AF_TH     = CNT_WIDTH'(ALMOST_FULL_THRESHOLD);
    localparam logic [CNT_WIDTH-1:0] AE_TH     = CNT_WIDTH'(ALMOST_EMPTY_THRESHOLD);

    logic [DATA_WIDTH-1:0] mem [TOTAL];

    logic [PTR_WIDTH-1:0] head  [NUM_QUEUES];
    logic [PTR_WIDTH-1:0] tail  [NUM_QUEUES];
    logic [CNT_WIDTH-1:0] count [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] ovf_r;
    logic [NUM_QUEUES-1:0] udf_r;

    logic                  deq_legal;
    logic                  enq_legal;
    logic [NUM_QUEUES-1:0] enq_hit;
    logic [NUM_QUEUES-1:0] deq_hit;
    logic [NUM_QUEUES-1:0] enq_drop;
    logic [NUM_QUEUES-1:0] deq_drop;

    always_comb begin
        full         = '0;
        almost_full  = '0;
        empty        = '0;
        almost_empty = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            full[q]         = (count[q] == DEPTH_CNT);
            almost_full[q]  = (count[q] >= AF_TH);
            empty[q]        = (count[q] == '0);
            almost_empty[q] = (count[q] <= AE_TH);
        end
    end

    assign overflow  = ovf_r;
    assign underflow = udf_r;

    // A full queue still accepts an enqueue when the same cycle pops it,
    // since the freed slot is reused at the same edge.
    always_comb begin
        deq_legal = dequeue_en && !empty[dequeue_qid];
        enq_legal = enqueue_en &&
                    (!full[enqueue_qid] || (deq_legal && (dequeue_qid == enqueue_qid)));
        enq_hit  = '0;
        deq_hit  = '0;
        enq_drop = '0;
        deq_drop = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            enq_hit[q]  = enq_legal && (enqueue_qid == QID_WIDTH'(q));
            deq_hit[q]  = deq_legal && (dequeue_qid == QID_WIDTH'(q));
            enq_drop[q] = enqueue_en && !enq_legal && (enqueue_qid == QID_WIDTH'(q));
            deq_drop[q] = dequeue_en && !deq_legal && (dequeue_qid == QID_WIDTH'(q));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                head[q]  <= '0;
                tail[q]  <= '0;
                count[q] <= '0;
            end
            ovf_r <= '0;
            udf_r <= '0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (flush_en[q]) begin
                    // Flush wins silently over any operation to this queue.
                    head[q]  <= '0;
                    tail[q]  <= '0;
                    count[q] <= '0;
                    ovf_r[q] <= 1'b0;
                    udf_r[q] <= 1'b0;
                end else begin
                    if (deq_hit[q]) head[q] <= head[q] + 1'b1;
                    if (enq_hit[q]) tail[q] <= tail[q] + 1'b1;
                    if (enq_hit[q] && !deq_hit[q])
                        count[q] <= count[q] + 1'b1;
                    else if (deq_hit[q] && !enq_hit[q])
                        count[q] <= count[q] - 1'b1;
                    if (enq_drop[q]) ovf_r[q] <= 1'b1;
                    if (deq_drop[q]) udf_r[q] <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (enq_legal && !flush_en[enqueue_qid])
            mem[{enqueue_qid, tail[enqueue_qid]}] <= value_i;
    end

    assign value_o = mem[ADDR_WIDTH'({dequeue_qid, head[dequeue_qid]})];

endmodule

// File: tb/tb_multi_queue_fifo.sv
module tb_multi_queue_fifo;

    localparam int DW = 64;
    localparam int NQ = 4;
    localparam int QW = 2;

    logic          clk;
    logic          reset_n;
    logic [NQ-1:0] flush_en;
    logic          enqueue_en;
    logic [QW-1:0] enqueue_qid;
    logic [DW-1:0] value_i;
    logic          dequeue_en;
    logic [QW-1:0] dequeue_qid;
    logic [DW-1:0] value_o;
    logic [NQ-1:0] full;
    logic [NQ-1:0] almost_full;
    logic [NQ-1:0] empty;
    logic [NQ-1:0] almost_empty;
    logic [NQ-1:0] overflow;
    logic [NQ-1:0] underflow;

    int n_checks = 0;
    int n_pass   = 0;

    multi_queue_fifo dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_en     (flush_en),
        .enqueue_en   (enqueue_en),
        .enqueue_qid  (enqueue_qid),
        .value_i      (value_i),
        .dequeue_en   (dequeue_en),
        .dequeue_qid  (dequeue_qid),
        .value_o      (value_o),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checker
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // drivers: inputs change 1 time unit after a rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_en   = '0;
        enqueue_en = 1'b0;
        dequeue_en = 1'b0;
    endtask

    task automatic enq(input logic [QW-1:0] q, input logic [DW-1:0] v);
        enqueue_en  = 1'b1;
        enqueue_qid = q;
        value_i     = v;
        cyc();
        enqueue_en  = 1'b0;
    endtask

    // Check the head of queue q, then pop it.
    task automatic deq_chk(input string tag, input logic [QW-1:0] q, input logic [DW-1:0] exp);
        dequeue_qid = q;
        #1;
        check(tag, value_o, exp);
        dequeue_en = 1'b1;
        cyc();
        dequeue_en = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        flush_en    = '0;
        enqueue_en  = 1'b0;
        enqueue_qid = '0;
        value_i     = '0;
        dequeue_en  = 1'b0;
        dequeue_qid = '0;
        cyc();
        cyc();

        // reset state
        check("rst_empty",   64'(empty),        64'hF);
        check("rst_aempty",  64'(almost_empty), 64'hF);
        check("rst_full",    64'(full),         64'h0);
        check("rst_afull",   64'(almost_full),  64'h0);
        check("rst_ovf",     64'(overflow),     64'h0);
        check("rst_udf",     64'(underflow),    64'h0);
        reset_n = 1'b1;
        cyc();

        // fill q2 with A0..A3
        enq(2'd2, 64'hA0);
        check("q2_c1_aempty", 64'(almost_empty), 64'hF);
        check("q2_c1_empty",  64'(empty),        64'hB);
        enq(2'd2, 64'hA1);
        check("q2_c2_aempty", 64'(almost_empty), 64'hB);
        enq(2'd2, 64'hA2);
        check("q2_c3_full",   64'(full),         64'h0);
        enq(2'd2, 64'hA3);
        check("q2_full",      64'(full),         64'h4);
        check("q2_afull",     64'(almost_full),  64'h4);
        check("q2_others",    64'(empty),        64'hB);
        deq_chk("q2_d0", 2'd2, 64'hA0);
        check("q2_notfull",   64'(full),         64'h0);
        deq_chk("q2_d1", 2'd2, 64'hA1);
        deq_chk("q2_d2", 2'd2, 64'hA2);
        deq_chk("q2_d3", 2'd2, 64'hA3);
        check("q2_drained",   64'(empty),        64'hF);
        check("q2_no_udf",    64'(underflow),    64'h0);

        // interleaved q0 / q3
        enq(2'd0, 64'h10);
        enq(2'd3, 64'h30);
        enq(2'd0, 64'h11);
        check("mix_empty", 64'(empty), 64'h6);
        deq_chk("mix_q3", 2'd3, 64'h30);
        deq_chk("mix_q0a", 2'd0, 64'h10);
        deq_chk("mix_q0b", 2'd0, 64'h11);
        check("mix_drained", 64'(empty), 64'hF);

        // q1 full: simultaneous enq+deq accepted, lone enq dropped
        enq(2'd1, 64'hB0);
        enq(2'd1, 64'hB1);
        enq(2'd1, 64'hB2);
        enq(2'd1, 64'hB3);
        check("q1_full", 64'(full), 64'h2);
        dequeue_qid = 2'd1;
        #1;
        check("q1_head", value_o, 64'hB0);
        dequeue_en  = 1'b1;
        enqueue_en  = 1'b1;
        enqueue_qid = 2'd1;
        value_i     = 64'hC0;
        cyc();
        idle();
        check("q1_both_full", 64'(full),     64'h2);
        check("q1_both_ovf",  64'(overflow), 64'h0);
        enq(2'd1, 64'hC1);
        check("q1_ovf",       64'(overflow), 64'h2);
        check("q1_still_full", 64'(full),    64'h2);
        deq_chk("q1_d1", 2'd1, 64'hB1);
        deq_chk("q1_d2", 2'd1, 64'hB2);
        deq_chk("q1_d3", 2'd1, 64'hB3);
        deq_chk("q1_dC0", 2'd1, 64'hC0);
        check("q1_drained",  64'(empty),    64'hF);
        check("q1_ovf_stky", 64'(overflow), 64'h2);

        // dequeue empty q0 while enqueueing 0x55 to q0
        dequeue_qid = 2'd0;
        dequeue_en  = 1'b1;
        enqueue_en  = 1'b1;
        enqueue_qid = 2'd0;
        value_i     = 64'h55;
        cyc();
        idle();
        #1;
        check("q0_udf",    64'(underflow),    64'h1);
        check("q0_nempty", 64'(empty),        64'hE);
        check("q0_aempty", 64'(almost_empty), 64'hF);
        check("q0_val",    value_o,           64'h55);
        deq_chk("q0_pop", 2'd0, 64'h55);
        check("q0_cnt1",   64'(empty),        64'hF);

        // flush q2 while enqueueing q2 and dequeueing q1
        dequeue_qid = 2'd2;
        dequeue_en  = 1'b1;
        cyc();
        dequeue_en  = 1'b0;
        check("q2_udf", 64'(underflow), 64'h5);
        enq(2'd2, 64'hD0);
        enq(2'd2, 64'hD1);
        enq(2'd2, 64'hD2);
        enq(2'd1, 64'hE0);
        enq(2'd1, 64'hE1);
        flush_en    = 4'b0100;
        enqueue_en  = 1'b1;
        enqueue_qid = 2'd2;
        value_i     = 64'hF0;
        dequeue_en  = 1'b1;
        dequeue_qid = 2'd1;
        cyc();
        idle();
        check("fl_q2_empty", 64'(empty),        64'hD);
        check("fl_ovf",      64'(overflow),     64'h2);
        check("fl_udf",      64'(underflow),    64'h1);
        check("fl_q1_cnt1",  64'(almost_empty), 64'hF);
        deq_chk("fl_q1_E1", 2'd1, 64'hE1);
        check("fl_q1_empty", 64'(empty),        64'hF);
        enq(2'd2, 64'h60);
        deq_chk("fl_q2_reuse", 2'd2, 64'h60);

        // wrap q3 with back-to-back enq/deq pairs
        enq(2'd3, 64'h300);
        for (int i = 1; i <= 10; i++) begin
            dequeue_qid = 2'd3;
            #1;
            check("wrap_val", value_o, 64'h300 + 64'(i - 1));
            dequeue_en  = 1'b1;
            enqueue_en  = 1'b1;
            enqueue_qid = 2'd3;
            value_i     = 64'h300 + 64'(i);
            cyc();
            idle();
            check("wrap_cnt1", 64'(empty & 4'h8) | 64'(almost_empty & 4'h8), 64'h8 & ~64'(empty & 4'h8));
        end
        deq_chk("wrap_last", 2'd3, 64'h30A);
        check("wrap_empty", 64'(empty), 64'hF);
        check("wrap_ovf",   64'(overflow),  64'h2);

        // asynchronous reset mid-stream
        enq(2'd0, 64'h71);
        enq(2'd3, 64'h72);
        check("pre_rst_empty", 64'(empty), 64'h6);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_empty", 64'(empty),     64'hF);
        check("arst_ovf",   64'(overflow),  64'h0);
        check("arst_udf",   64'(underflow), 64'h0);
        cyc();
        reset_n = 1'b1;
        enq(2'd1, 64'h77);
        check("post_rst_empty", 64'(empty), 64'hD);
        deq_chk("post_rst_val", 2'd1, 64'h77);
        check("post_rst_drained", 64'(empty), 64'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
